reg_if_ctrl: RTL



---
 rtl/reg_if_pkg.sv | 9 +
 rtl/reg_if_ctrl_timeout_cnt.sv | 18 +
 rtl/reg_if_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/reg_if_pkg.sv
// reg_if_pkg: shared states and response constants for the register-interface sequencer
package reg_if_pkg;
   typedef enum logic [2:0] {
      IDLE, GET_DATA, WR, RD_REQ, RD_WAIT, TX_WAIT, TX_SEND, TX_GAP
   } state_t;
   localparam logic [7:0] ACK_BYTE   = 8'hAA;
   localparam logic [7:0] NAK_BYTE   = 8'hEE;
   localparam int         CMD_WR_BIT = 7;
endpackage

// File: rtl/reg_if_ctrl_timeout_cnt.sv
// timeout_cnt: cycle counter that flags when the count equals the terminal value
module timeout_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear_i,
   input  logic         en_i,
   input  logic [W-1:0] limit_i,
   output logic         done_o
);
   logic [W-1:0] cnt_q, cnt_d;
   // clear wins over count; the owning state exits at the limit so no wrap handling is needed
   always_comb cnt_d = clear_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
   // counter register
   always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
   assign done_o = cnt_q == limit_i;
endmodule

// File: rtl/reg_if_ctrl.sv
// reg_if_ctrl: parses UART command frames into register strobes and returns one response byte
module reg_if_ctrl
   import reg_if_pkg::*;
#(
   parameter int ADDR_W  = 7,
   parameter int BYTE_TO = 100000,
   parameter int RD_TO   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_write,
   output logic              reg_read,
   input  logic [7:0]        reg_rdata,
   input  logic              reg_valid,
   output logic              err
);
   localparam int MAX_TO = BYTE_TO > RD_TO ? BYTE_TO : RD_TO;
   localparam int CW     = MAX_TO > 1 ? $clog2(MAX_TO) : 1;
   state_t            state_q, state_d;
   logic [7:0]        tx_data_q, tx_data_d, wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              done;
   timeout_cnt #(.W(CW)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (state_q == IDLE || state_q == RD_REQ),
      .en_i    (state_q == GET_DATA || state_q == RD_WAIT),
      .limit_i (state_q == RD_WAIT ? CW'(RD_TO - 1) : CW'(BYTE_TO - 1)),
      .done_o  (done)
   );
   // frame sequencing: a data byte or read data arriving on the timeout cycle still wins
   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      case (state_q)
         IDLE:     if (rx_valid) begin
            addr_d  = rx_data[ADDR_W-1:0];
            state_d = rx_data[CMD_WR_BIT] ? GET_DATA : RD_REQ;
         end
         GET_DATA: if (rx_valid) begin
            wdata_d = rx_data;
            state_d = WR;
         end else if (done) state_d = IDLE;
         WR:       begin
            tx_data_d = ACK_BYTE;
            state_d   = TX_WAIT;
         end
         RD_REQ:   state_d = RD_WAIT;
         RD_WAIT:  if (reg_valid || done) begin
            tx_data_d = reg_valid ? reg_rdata : NAK_BYTE;
            state_d   = TX_WAIT;
         end
         TX_WAIT:  if (!tx_busy) state_d = TX_SEND;
         TX_SEND:  state_d = TX_GAP;
         default:  state_d = IDLE;
      endcase
   end
   // state and datapath registers
   always_ff @(posedge clk) begin
      state_q   <= rst ? IDLE : state_d;
      tx_data_q <= rst ? '0 : tx_data_d;
      addr_q    <= rst ? '0 : addr_d;
      wdata_q   <= rst ? '0 : wdata_d;
   end
   assign reg_write = !rst && state_q == WR;
   assign reg_read  = !rst && state_q == RD_REQ;
   assign tx_start  = !rst && state_q == TX_SEND;
   assign err       = !rst && ((rx_valid && state_q != IDLE && state_q != GET_DATA)
                            || (state_q == GET_DATA && done && !rx_valid)
                            || (state_q == RD_WAIT && done && !reg_valid));
   assign tx_data   = tx_data_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
endmodule
